// File: rtl/mux2_rr_arbiter.sv
// Round-robin, burst-bounded sequencer for the shared 2:1 mux (out = sel_c ? A : B); ARB_STATS_EN adds beat counters.
// One arbitration cycle before the first grant; the output word registers one cycle after the transfer; out_ready low stalls both readies.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel_c,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef ARB_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [7:0]       grant_cnt_a,
  output logic [7:0]       grant_cnt_b
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic [3:0]       beat_cnt_q, beat_cnt_d;
  logic             last_a_q, last_a_d;
  logic             sel_c_q, sel_c_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic load;
  logic a_xfer;
  logic b_xfer;
  logic rearb;
  logic enter_a;
  logic enter_b;

  always_comb begin
    load    = !out_valid_q || out_ready;
    a_ready = load && (state_q == GRANT_A);
    b_ready = load && (state_q == GRANT_B);
    a_xfer  = a_valid && a_ready;
    b_xfer  = b_valid && b_ready;
  end

  always_comb begin
    rearb = 1'b1;
    case (state_q)
      IDLE:    rearb = 1'b1;
      GRANT_A: rearb = !a_valid || (a_xfer && (beat_cnt_q == LAST_BEAT));
      GRANT_B: rearb = !b_valid || (b_xfer && (beat_cnt_q == LAST_BEAT));
      default: rearb = 1'b1;
    endcase
    // The side that did not hold the last grant wins a tie; a lone requester always wins.
    enter_a = rearb && a_valid && (!b_valid || !last_a_q);
    enter_b = rearb && b_valid && (!a_valid || last_a_q);
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    last_a_d   = last_a_q;
    sel_c_d    = sel_c_q;

    if (a_xfer || b_xfer) begin
      beat_cnt_d = beat_cnt_q + 4'd1;
    end

    if (enter_a) begin
      state_d    = GRANT_A;
      beat_cnt_d = 4'd0;
      last_a_d   = 1'b1;
      sel_c_d    = 1'b1;
    end else if (enter_b) begin
      state_d    = GRANT_B;
      beat_cnt_d = 4'd0;
      last_a_d   = 1'b0;
      sel_c_d    = 1'b0;
    end else if (rearb) begin
      state_d = IDLE;
    end
  end

  // sel_c_q already points at the granted side, so the shared mux picks the word.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    if (a_xfer || b_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_c_q ? a_data : b_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= 4'd0;
      last_a_q    <= 1'b0;
      sel_c_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      last_a_q    <= last_a_d;
      sel_c_q     <= sel_c_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign sel_c     = sel_c_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef ARB_STATS_EN
  logic [7:0] cnt_a_q, cnt_a_d;
  logic [7:0] cnt_b_q, cnt_b_d;

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (stats_clr) begin
      cnt_a_d = 8'd0;
      cnt_b_d = 8'd0;
    end else begin
      if (a_xfer && (cnt_a_q != 8'hFF)) cnt_a_d = cnt_a_q + 8'd1;
      if (b_xfer && (cnt_b_q != 8'hFF)) cnt_b_d = cnt_b_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= 8'd0;
      cnt_b_q <= 8'd0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign grant_cnt_a = cnt_a_q;
  assign grant_cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: two instances (MAX_BURST 4 and 2) checked every cycle against a grant-turn reference model.
module tb_mux2_rr_arbiter;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic         a_valid[2], b_valid[2], out_ready[2];
  logic [W-1:0] a_data[2], b_data[2];
  logic         a_ready[2], b_ready[2], sel_c[2], out_valid[2];
  logic [W-1:0] out_data[2];
`ifdef ARB_STATS_EN
  logic       stats_clr;
  logic [7:0] gca[2], gcb[2];
`endif

  mux2_rr_arbiter #(.WIDTH(W), .MAX_BURST(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid[0]), .a_data(a_data[0]), .a_ready(a_ready[0]),
    .b_valid(b_valid[0]), .b_data(b_data[0]), .b_ready(b_ready[0]),
    .sel_c(sel_c[0]), .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0])
`ifdef ARB_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt_a(gca[0]), .grant_cnt_b(gcb[0])
`endif
  );

  mux2_rr_arbiter #(.WIDTH(W), .MAX_BURST(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid[1]), .a_data(a_data[1]), .a_ready(a_ready[1]),
    .b_valid(b_valid[1]), .b_data(b_data[1]), .b_ready(b_ready[1]),
    .sel_c(sel_c[1]), .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1])
`ifdef ARB_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt_a(gca[1]), .grant_cnt_b(gcb[1])
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int nb1 = 0;

  // Reference model: owner 0 = nobody, 1 = A, 2 = B.
  int         mb[2];
  int         m_own[2], m_beats[2], m_last[2], m_ca[2], m_cb[2];
  bit         m_sel[2], m_ov[2];
  logic [W-1:0] m_od[2];

  // Requester stimulus state.
  int         a_rem[2], b_rem[2], a_pct[2], b_pct[2], or_pct[2];
  bit         a_on[2], b_on[2], a_seq[2], b_seq[2], acc_a[2], acc_b[2];
  logic [W-1:0] a_cur[2], b_cur[2];

  int dl0[$];
  int dl1[$];
  int exp2[15] = '{1, 2, 3, 4, 9, 10, 11, 12, 5, 6, 7, 8, 13, 14, 15};

  task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h exp=%0h t=%0t", tag, idx, got, exp, $time);
    end
  endtask

  function automatic bit want(input int k, input int s);
    return (s == 1) ? a_valid[k] : b_valid[k];
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = 0; m_beats[k] = 0; m_last[k] = 2;
      m_sel[k] = 1'b0; m_ov[k] = 1'b0; m_od[k] = '0;
      m_ca[k] = 0; m_cb[k] = 0;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      if (acc_a[k]) begin
        a_rem[k]--; a_on[k] = 1'b0;
        a_cur[k] = a_seq[k] ? a_cur[k] + 4'd1 : 4'($urandom);
      end
      if (acc_b[k]) begin
        b_rem[k]--; b_on[k] = 1'b0;
        b_cur[k] = b_seq[k] ? b_cur[k] + 4'd1 : 4'($urandom);
      end
      if (!a_on[k] && a_rem[k] > 0 && int'($urandom_range(99)) < a_pct[k]) a_on[k] = 1'b1;
      if (!b_on[k] && b_rem[k] > 0 && int'($urandom_range(99)) < b_pct[k]) b_on[k] = 1'b1;
      a_valid[k] = a_on[k]; a_data[k] = a_cur[k];
      b_valid[k] = b_on[k]; b_data[k] = b_cur[k];
      out_ready[k] = int'($urandom_range(99)) < or_pct[k];
      acc_a[k] = 1'b0; acc_b[k] = 1'b0;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    for (int k = 0; k < 2; k++) begin
      bit ld, ea, eb, xa, xb, done;
      int oth, pick;
      ld = !m_ov[k] || out_ready[k];
      ea = ld && (m_own[k] == 1);
      eb = ld && (m_own[k] == 2);
      chk("a_ready", k, 32'(a_ready[k]), 32'(ea));
      chk("b_ready", k, 32'(b_ready[k]), 32'(eb));
      chk("sel_c", k, 32'(sel_c[k]), 32'(m_sel[k]));
      chk("out_valid", k, 32'(out_valid[k]), 32'(m_ov[k]));
      chk("out_data", k, 32'(out_data[k]), 32'(m_od[k]));
`ifdef ARB_STATS_EN
      chk("grant_cnt_a", k, 32'(gca[k]), 32'(m_ca[k]));
      chk("grant_cnt_b", k, 32'(gcb[k]), 32'(m_cb[k]));
`endif
      if (k == 1 && b_ready[1]) nb1++;
      xa = ea && a_valid[k];
      xb = eb && b_valid[k];
      acc_a[k] = xa; acc_b[k] = xb;
      if (m_ov[k] && out_ready[k]) begin
        if (k == 0) dl0.push_back(cyc_n * 16 + int'(m_od[k]));
        else        dl1.push_back(cyc_n * 16 + int'(m_od[k]));
      end
      if (xa || xb) begin
        m_ov[k] = 1'b1;
        m_od[k] = xa ? a_data[k] : b_data[k];
        m_beats[k]++;
      end else if (out_ready[k]) begin
        m_ov[k] = 1'b0;
      end
`ifdef ARB_STATS_EN
      if (stats_clr) begin
        m_ca[k] = 0; m_cb[k] = 0;
      end else begin
        if (xa && m_ca[k] < 255) m_ca[k]++;
        if (xb && m_cb[k] < 255) m_cb[k]++;
      end
`endif
      done = (m_own[k] == 0) ||
             (m_own[k] == 1 && (!a_valid[k] || m_beats[k] == mb[k])) ||
             (m_own[k] == 2 && (!b_valid[k] || m_beats[k] == mb[k]));
      if (done) begin
        oth  = 3 - m_last[k];
        pick = want(k, oth) ? oth : (want(k, m_last[k]) ? m_last[k] : 0);
        m_own[k] = pick;
        if (pick != 0) begin
          m_beats[k] = 0; m_last[k] = pick; m_sel[k] = (pick == 1);
        end
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic clear_stim();
    for (int k = 0; k < 2; k++) begin
      a_rem[k] = 0; b_rem[k] = 0; a_on[k] = 1'b0; b_on[k] = 1'b0;
      acc_a[k] = 1'b0; acc_b[k] = 1'b0;
      a_seq[k] = 1'b1; b_seq[k] = 1'b1;
      a_pct[k] = 100; b_pct[k] = 100; or_pct[k] = 100;
      a_cur[k] = '0; b_cur[k] = '0;
      a_valid[k] = 1'b0; b_valid[k] = 1'b0; a_data[k] = '0; b_data[k] = '0;
      out_ready[k] = 1'b1;
    end
`ifdef ARB_STATS_EN
    stats_clr = 1'b0;
`endif
  endtask

  task automatic do_reset(input bit check_vals);
    clear_stim();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    if (check_vals) begin
      for (int k = 0; k < 2; k++) begin
        chk("rst_out_valid", k, 32'(out_valid[k]), 32'd0);
        chk("rst_out_data", k, 32'(out_data[k]), 32'd0);
        chk("rst_sel_c", k, 32'(sel_c[k]), 32'd0);
        chk("rst_a_ready", k, 32'(a_ready[k]), 32'd0);
        chk("rst_b_ready", k, 32'(b_ready[k]), 32'd0);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
    dl0.delete();
    dl1.delete();
    drive();
  endtask

  initial begin
    bit found;
    mb[0] = 4; mb[1] = 2;
    m_reset();

    // First grant latency from IDLE.
    do_reset(1'b1);
    a_rem[0] = 1; a_cur[0] = 4'h3; drive();
    #1 chk("lat_idle_a_ready", 0, 32'(a_ready[0]), 32'd0);
    cyc();
    #1 chk("lat_a_ready", 0, 32'(a_ready[0]), 32'd1);
    chk("lat_sel_c", 0, 32'(sel_c[0]), 32'd1);
    cyc();
    chk("lat_out_valid", 0, 32'(out_valid[0]), 32'd1);
    chk("lat_out_data", 0, 32'(out_data[0]), 32'd3);
    repeat (3) cyc();

    // Interleaved bursts with both requesters always valid.
    do_reset(1'b0);
    a_rem[0] = 8; a_cur[0] = 4'h1; b_rem[0] = 7; b_cur[0] = 4'h9; drive();
    repeat (22) cyc();
    chk("order_len", 0, 32'(dl0.size()), 32'd15);
    for (int i = 0; i < 15 && i < int'(dl0.size()); i++) begin
      chk("order_word", i, 32'(dl0[i] % 16), 32'(exp2[i]));
      chk("order_gap", i, 32'(dl0[i] / 16 - dl0[0] / 16), 32'(i));
    end

    // Lone A stream on the MAX_BURST=2 instance.
    do_reset(1'b0);
    nb1 = 0;
    a_rem[1] = 12; a_cur[1] = 4'h0; drive();
    repeat (20) cyc();
    chk("solo_len", 1, 32'(dl1.size()), 32'd12);
    for (int i = 0; i < 12 && i < int'(dl1.size()); i++) begin
      chk("solo_word", i, 32'(dl1[i] % 16), 32'(i));
      chk("solo_gap", i, 32'(dl1[i] / 16 - dl1[0] / 16), 32'(i));
    end
    chk("solo_b_ready_seen", 1, 32'(nb1), 32'd0);

    // Output stall mid-burst while holding word 6.
    do_reset(1'b0);
    a_rem[0] = 6; a_cur[0] = 4'h4; drive();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (out_valid[0] && out_data[0] == 4'h6) found = 1'b1;
    end
    chk("stall_seen", 0, 32'(found), 32'd1);
    or_pct[0] = 0; out_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_a_ready", i, 32'(a_ready[0]), 32'd0);
      chk("stall_out_data", i, 32'(out_data[0]), 32'd6);
      cyc();
    end
    or_pct[0] = 100; out_ready[0] = 1'b1;
    repeat (15) cyc();
    chk("stall_len", 0, 32'(dl0.size()), 32'd6);
    for (int i = 0; i < 6 && i < int'(dl0.size()); i++) begin
      chk("stall_word", i, 32'(dl0[i] % 16), 32'(i + 4));
    end

    // Reset while B holds an output word, then a tie goes to A.
    do_reset(1'b0);
    b_rem[0] = 4; b_cur[0] = 4'hA; drive();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (out_valid[0]) found = 1'b1;
    end
    chk("rstmid_setup", 0, 32'(found), 32'd1);
    clear_stim();
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", 0, 32'(out_valid[0]), 32'd0);
    chk("rstmid_sel_c", 0, 32'(sel_c[0]), 32'd0);
    chk("rstmid_b_ready", 0, 32'(b_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
    a_rem[0] = 1; a_cur[0] = 4'h1; b_rem[0] = 1; b_cur[0] = 4'h2; drive();
    cyc();
    #1;
    chk("rstmid_a_first", 0, 32'(a_ready[0]), 32'd1);
    chk("rstmid_b_wait", 0, 32'(b_ready[0]), 32'd0);
    chk("rstmid_sel_a", 0, 32'(sel_c[0]), 32'd1);
    repeat (6) cyc();

    // Randomised traffic with back-pressure on both instances.
    do_reset(1'b0);
    for (int k = 0; k < 2; k++) begin
      a_seq[k] = 1'b0; b_seq[k] = 1'b0;
      a_rem[k] = 100000; b_rem[k] = 100000;
      a_pct[k] = int'($urandom_range(90, 30));
      b_pct[k] = int'($urandom_range(90, 30));
      or_pct[k] = 60;
      a_cur[k] = 4'($urandom); b_cur[k] = 4'($urandom);
    end
    drive();
    repeat (1500) cyc();

`ifdef ARB_STATS_EN
    // Saturation and clear-over-increment priority.
    do_reset(1'b0);
    a_rem[0] = 300; a_cur[0] = 4'h0; drive();
    repeat (310) cyc();
    chk("stats_sat_a", 0, 32'(gca[0]), 32'd255);
    b_rem[0] = 1; b_cur[0] = 4'h5; drive();
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      #1;
      if (b_ready[0] && b_valid[0]) begin
        stats_clr = 1'b1;
        found = 1'b1;
      end
      cyc();
      stats_clr = 1'b0;
    end
    chk("stats_clr_seen", 0, 32'(found), 32'd1);
    #1;
    chk("stats_clr_a", 0, 32'(gca[0]), 32'd0);
    chk("stats_clr_b", 0, 32'(gcb[0]), 32'd0);
    repeat (3) cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
Sequencer for the shared 2:1 datapath mux (out = C ? A : B). Two requesters (A, B) present data with valid/ready handshakes; the block arbitrates round-robin with bounded bursts, drives the mux select, and registers the selected word into a single output stage with its own valid/ready. It sits between two producers and one shared downstream consumer.

Parameters:
WIDTH, 4, data width of A, B and out.
MAX_BURST, 4, max beats per grant before forced re-arbitration; legal range 1..15.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
a_valid  in  1  requester A has a word.
a_data  in  WIDTH  requester A word.
a_ready  out  1  A beat accepted this cycle when a_valid && a_ready.
b_valid  in  1  requester B has a word.
b_data  in  WIDTH  requester B word.
b_ready  out  1  B beat accepted this cycle when b_valid && b_ready.
sel_c  out  1  mux select; 1 = A, 0 = B; registered.
out_valid  out  1  output register holds a word.
out_data  out  WIDTH  output word.
out_ready  in  1  consumer accepts when out_valid && out_ready.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, last_grant=B (A wins the first tie), beat_cnt=0, sel_c=0, out_valid=0, out_data=0, a_ready=b_ready=0. Reset mid-operation drops any held output word and any in-progress burst immediately.
- States: IDLE, GRANT_A, GRANT_B; 2-bit state register; beat_cnt is 4 bits.
- load = !out_valid || out_ready.
- a_ready = load && state==GRANT_A; b_ready = load && state==GRANT_B. Both are never 1 together. Both are 0 in IDLE.
- IDLE transitions:
  - both valid -> grant the side != last_grant.
  - only a_valid -> GRANT_A.
  - only b_valid -> GRANT_B.
  - none -> stay IDLE.
  - On entering GRANT_x: sel_c updated, beat_cnt=0, last_grant=x.
- GRANT_A: each A transfer loads out_data<=a_data, sets out_valid=1, beat_cnt++.
  - Exit when !a_valid, or when an A transfer makes beat_cnt reach MAX_BURST.
  - On exit: b_valid -> GRANT_B. Otherwise a_valid (burst exhausted, B idle) -> re-enter GRANT_A with beat_cnt=0. Otherwise IDLE.
  - GRANT_B is symmetric.
- Requesters must hold valid/data until accepted. A requester dropping valid without a transfer is treated as !valid; exit follows the rule above.
- Output stage: when out_valid && out_ready and no new load, out_valid<=0. A simultaneous drain and load replaces the word with no bubble (full throughput within a burst).
- Latency:
  - From a_valid rising in IDLE, a_ready asserts the next cycle (one arbitration cycle).
  - out_valid asserts the cycle after the transfer.
  - Switching between grants costs zero idle cycles: the next grant is active the cycle after the exit condition.
- Back-pressure: out_ready=0 with out_valid=1 forces a_ready=b_ready=0. State and beat_cnt hold.
- beat_cnt counts only transfers, never stall cycles.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, three ports are added:
  - stats_clr (in, 1): synchronous clear of both counters.
  - grant_cnt_a (out, 8): A beats transferred, saturating at 255; reset 0.
  - grant_cnt_b (out, 8): B beats transferred, saturating at 255; reset 0.
- stats_clr has priority over an increment in the same cycle.
- When not defined, these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Reset then a_valid=1, a_data=4'h3, b idle, out_ready=1 -> a_ready at cycle 2, out_data=3 with out_valid at cycle 3, sel_c=1.
- Both always valid, MAX_BURST=4, out_ready=1, A sends 1..8, B sends 9..F -> output order 1,2,3,4,9,A,B,C,5,6,7,8,D,E,F, with no gap cycles after the first word.
- Only A always valid, MAX_BURST=2 -> continuous A stream; GRANT_A re-entered every 2 beats, no bubbles, b_ready stays 0.
- Out_ready=0 for 5 cycles mid-burst with out_data=4'h6 -> out_data holds 6, a_ready=0, beat_cnt unchanged; stream resumes without loss or duplication.
- rst_n pulsed low while out_valid=1 in GRANT_B -> out_valid=0, sel_c=0, state IDLE in the same cycle. With both then valid, A is granted first.
- With ARB_STATS_EN: 300 A beats then stats_clr together with a B beat -> grant_cnt_a=255 before the clear, both counters 0 after it.
